// File: rtl/pulse_stretch_pkg.sv
// Shared types and defaults for the pulse stretcher: state encoding,
// default timing constants and the counter width helper.
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ON   = 2'b01,
      GAP  = 2'b10
   } state_t;

   localparam int DEF_ON_CYCLES  = 16;
   localparam int DEF_GAP_CYCLES = 8;
   localparam int DEF_PEND_W     = 3;

   // Wide enough to hold the larger of the two phase lengths.
   function automatic int cnt_width(input int on_cycles, input int gap_cycles);
      int longest;
      longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for pin-facing inputs: registers D and flags D & ~D_DLY.
// D_DLY clears on reset, so an input already high at reset release reports one edge.
module rise_detect (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic D_DLY,
   output logic RISE
);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) D_DLY <= 1'b0;
      else     D_DLY <= D;
   end

   assign RISE = D & ~D_DLY;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches short event pulses to ON_CYCLES high / GAP_CYCLES low, queueing extra
// events in a saturating counter. Define PULSE_STRETCH_RETRIG_EN to retrigger during ON.
module pulse_stretcher
   import pulse_stretch_pkg::*;
#(
   parameter int ON_CYCLES  = DEF_ON_CYCLES,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES,
   parameter int PEND_W     = DEF_PEND_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EV,
   output logic              Q,
   output logic              BUSY,
   output logic [PEND_W-1:0] PEND,
   output logic              OVF
);

   localparam int                CW         = cnt_width(ON_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0]     ON_RELOAD  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0]     GAP_RELOAD = CW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = '1;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [PEND_W-1:0]   pend, pend_nxt;
   logic                ovf, ovf_nxt;
   logic                ev_d;
   logic                ev_edge;
   logic                queue_ev;

   rise_detect u_rise (
      .CLK   (CLK),
      .RST   (RST),
      .D     (EV),
      .D_DLY (ev_d),
      .RISE  (ev_edge)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pend  <= pend_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      pend_nxt  = pend;
      ovf_nxt   = 1'b0;
      queue_ev  = 1'b0;

      case (state)
         IDLE: begin
            if (ev_edge) begin
               state_nxt = ON;
               cnt_nxt   = ON_RELOAD;
            end
         end

         ON: begin
`ifdef PULSE_STRETCH_RETRIG_EN
            if (ev_edge) begin
               cnt_nxt = ON_RELOAD;
            end else if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_RELOAD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
`else
            queue_ev = ev_edge;
            if (cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_RELOAD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
`endif
         end

         GAP: begin
            if (cnt == '0) begin
               if (pend != '0 || ev_edge) begin
                  state_nxt = ON;
                  cnt_nxt   = ON_RELOAD;
                  // A fresh edge replaces the pending event it would otherwise consume.
                  if (!ev_edge) pend_nxt = pend - PEND_W'(1);
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt  = cnt - CW'(1);
               queue_ev = ev_edge;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      if (queue_ev) begin
         if (pend == PEND_MAX) ovf_nxt  = 1'b1;
         else                  pend_nxt = pend + PEND_W'(1);
      end
   end

   assign Q    = (state == ON);
   assign BUSY = (state != IDLE);
   assign PEND = pend;
   assign OVF  = ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
// Bit i of each vector is the EV level driven in cycle i / the output expected after that edge.
module tb_pulse_stretcher;

   logic       CLK;
   logic       RST;
   logic       EV;
   logic       Q;
   logic       BUSY;
   logic [1:0] PEND;
   logic       OVF;

   int checks = 0;
   int errors = 0;

   int pend_burst [32] = '{0,0,1,1,2,2,1,2,2,3,3,3,2,2,2,2,2,2,1,1,1,1,1,1,0,0,0,0,0,0,0,0};

   pulse_stretcher #(
      .ON_CYCLES  (4),
      .GAP_CYCLES (2),
      .PEND_W     (2)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .EV   (EV),
      .Q    (Q),
      .BUSY (BUSY),
      .PEND (PEND),
      .OVF  (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive EV for one cycle and land 1 time unit after the sampling edge.
   task automatic tick(input logic ev);
      EV = ev;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      EV  = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      checks++;
      if ({Q, BUSY, PEND, OVF} !== 5'b0) begin
         errors++;
         $display("FAIL reset_state got Q=%b BUSY=%b PEND=%0d OVF=%b want all 0", Q, BUSY, PEND, OVF);
      end
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0);
         checks++;
         if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle tick %0d BUSY got %b want 0", i, BUSY);
         end
      end
   endtask

   task automatic test_single;
      logic [7:0] ev_v   = 8'h01;
      logic [7:0] q_v    = 8'h0F;
      logic [7:0] busy_v = 8'h3F;
      for (int i = 0; i < 8; i++) begin
         tick(ev_v[i]);
         checks++;
         if (Q !== q_v[i] || BUSY !== busy_v[i] || PEND !== 2'd0) begin
            errors++;
            $display("FAIL single tick %0d got Q=%b BUSY=%b PEND=%0d want Q=%b BUSY=%b PEND=0",
                     i, Q, BUSY, PEND, q_v[i], busy_v[i]);
         end
      end
   endtask

   task automatic test_held;
      logic [23:0] ev_v   = 24'h0F_FFFF;
      logic [23:0] q_v    = 24'h00_000F;
      logic [23:0] busy_v = 24'h00_003F;
      for (int i = 0; i < 24; i++) begin
         tick(ev_v[i]);
         checks++;
         if (Q !== q_v[i] || BUSY !== busy_v[i] || PEND !== 2'd0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL held tick %0d got Q=%b BUSY=%b PEND=%0d OVF=%b want Q=%b BUSY=%b PEND=0 OVF=0",
                     i, Q, BUSY, PEND, OVF, q_v[i], busy_v[i]);
         end
      end
   endtask

   task automatic test_burst_ovf;
      logic [31:0] ev_v   = 32'h0000_0A95;
      logic [31:0] q_v    = 32'h0F3C_F3CF;
      logic [31:0] busy_v = 32'h3FFF_FFFF;
      logic [31:0] ovf_v  = 32'h0000_0800;
      for (int i = 0; i < 32; i++) begin
         tick(ev_v[i]);
         checks++;
         if (Q !== q_v[i] || BUSY !== busy_v[i] || PEND !== 2'(pend_burst[i]) || OVF !== ovf_v[i]) begin
            errors++;
            $display("FAIL burst tick %0d got Q=%b BUSY=%b PEND=%0d OVF=%b want Q=%b BUSY=%b PEND=%0d OVF=%b",
                     i, Q, BUSY, PEND, OVF, q_v[i], busy_v[i], pend_burst[i], ovf_v[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [13:0] ev_v   = 14'h0041;
      logic [13:0] q_v    = 14'h03CF;
      logic [13:0] busy_v = 14'h0FFF;
      for (int i = 0; i < 14; i++) begin
         tick(ev_v[i]);
         checks++;
         if (Q !== q_v[i] || BUSY !== busy_v[i] || PEND !== 2'd0) begin
            errors++;
            $display("FAIL back_to_back tick %0d got Q=%b BUSY=%b PEND=%0d want Q=%b BUSY=%b PEND=0",
                     i, Q, BUSY, PEND, q_v[i], busy_v[i]);
         end
      end
   endtask

   task automatic test_mid_on_reset;
      tick(1'b1);
      tick(1'b0);
      tick(1'b1);
      checks++;
      if (Q !== 1'b1 || PEND !== 2'd1) begin
         errors++;
         $display("FAIL pre_reset got Q=%b PEND=%0d want Q=1 PEND=1", Q, PEND);
      end
      EV = 1'b0;
      #3 RST = 1'b1;
      #1;
      checks++;
      if ({Q, BUSY, PEND, OVF} !== 5'b0) begin
         errors++;
         $display("FAIL async_reset got Q=%b BUSY=%b PEND=%0d OVF=%b want all 0", Q, BUSY, PEND, OVF);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0);
         checks++;
         if (Q !== 1'b0 || BUSY !== 1'b0 || PEND !== 2'd0) begin
            errors++;
            $display("FAIL post_reset tick %0d got Q=%b BUSY=%b PEND=%0d want 0 0 0", i, Q, BUSY, PEND);
         end
      end
   endtask

   task automatic test_release_with_ev;
      logic [9:0] ev_v   = 10'h0FF;
      logic [9:0] q_v    = 10'h00F;
      logic [9:0] busy_v = 10'h03F;
      RST = 1'b1;
      EV  = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(ev_v[i]);
         checks++;
         if (Q !== q_v[i] || BUSY !== busy_v[i] || PEND !== 2'd0) begin
            errors++;
            $display("FAIL release_ev tick %0d got Q=%b BUSY=%b PEND=%0d want Q=%b BUSY=%b PEND=0",
                     i, Q, BUSY, PEND, q_v[i], busy_v[i]);
         end
      end
   endtask

   task automatic test_on_edge;
`ifdef PULSE_STRETCH_RETRIG_EN
      logic [13:0] q_v    = 14'h007F;
      logic [13:0] busy_v = 14'h01FF;
      logic [13:0] pend_v = 14'h0000;
`else
      logic [13:0] q_v    = 14'h03CF;
      logic [13:0] busy_v = 14'h0FFF;
      logic [13:0] pend_v = 14'h0038;
`endif
      logic [13:0] ev_v   = 14'h0009;
      for (int i = 0; i < 14; i++) begin
         tick(ev_v[i]);
         checks++;
         if (Q !== q_v[i] || BUSY !== busy_v[i] || PEND !== {1'b0, pend_v[i]}) begin
            errors++;
            $display("FAIL on_edge tick %0d got Q=%b BUSY=%b PEND=%0d want Q=%b BUSY=%b PEND=%0d",
                     i, Q, BUSY, PEND, q_v[i], busy_v[i], pend_v[i]);
         end
      end
   endtask

   initial begin
      RST = 1'b1;
      EV  = 1'b0;
      test_reset();
      test_single();
      test_held();
      test_burst_ovf();
      test_back_to_back();
      test_on_edge();
      test_mid_on_reset();
      test_release_with_ev();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
